// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: one valid/ready word read per instruction, word held until the core
// commits it. Optional watchdog on the memory handshake is built when YSYX_24100005_IFU_TIMEOUT_EN
// is defined.
module ysyx_24100005_ifu #(
  parameter logic [31:0] RESET_PC       = 32'h8000_0000,
  parameter logic [31:0] NOP_INST       = 32'h0000_0013,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        fetch_en,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StFault} state_e;

  localparam logic [1:0] CauseNone     = 2'b00;
  localparam logic [1:0] CauseMisalign = 2'b01;
  localparam logic [1:0] CauseBusErr   = 2'b10;
  localparam logic [1:0] CauseTimeout  = 2'b11;

  if (TIMEOUT_CYCLES < 8 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 8..65535");
  end

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] inst_q, inst_d;
  logic [1:0]  cause_q, cause_d;

`ifdef YSYX_24100005_IFU_TIMEOUT_EN
  localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);
  logic [15:0] cnt_q, cnt_d;
  logic        expired;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    cause_d = cause_q;
`ifdef YSYX_24100005_IFU_TIMEOUT_EN
    cnt_d   = cnt_q;
    expired = 1'b0;
    if (state_q == StReq || state_q == StWait) begin
      cnt_d   = cnt_q + 16'd1;
      expired = (cnt_d >= TimeoutLimit);
    end
`endif
    unique case (state_q)
      StIdle: begin
        if (fetch_en) begin
          if (pc[1:0] != 2'b00) begin
            state_d = StFault;
            cause_d = CauseMisalign;
          end else begin
            state_d = StReq;
            addr_d  = pc;
`ifdef YSYX_24100005_IFU_TIMEOUT_EN
            cnt_d   = 16'd0;
`endif
          end
        end
      end
      StReq: begin
        // Any response here is illegal by protocol and deliberately ignored.
        if (imem_req_ready) begin
          state_d = StWait;
`ifdef YSYX_24100005_IFU_TIMEOUT_EN
        end else if (expired) begin
          state_d = StFault;
          cause_d = CauseTimeout;
`endif
        end
      end
      StWait: begin
        if (imem_rsp_valid) begin
          if (imem_rsp_err) begin
            state_d = StFault;
            cause_d = CauseBusErr;
          end else begin
            state_d = StHold;
            inst_d  = imem_rsp_data;
          end
`ifdef YSYX_24100005_IFU_TIMEOUT_EN
        end else if (expired) begin
          state_d = StFault;
          cause_d = CauseTimeout;
`endif
        end
      end
      StHold: begin
        if (inst_ready) state_d = StIdle;
      end
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= RESET_PC;
      inst_q  <= NOP_INST;
      cause_q <= CauseNone;
`ifdef YSYX_24100005_IFU_TIMEOUT_EN
      cnt_q   <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      cause_q <= cause_d;
`ifdef YSYX_24100005_IFU_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Outputs depend only on registered state, never on inputs.
  assign inst_valid     = (state_q == StHold);
  assign inst           = inst_valid ? inst_q : NOP_INST;
  assign imem_req_valid = (state_q == StReq);
  assign imem_req_addr  = addr_q;
  assign fault          = (state_q == StFault);
  assign fault_cause    = cause_q;

endmodule
